// File: rtl/tage_buffer_sequencer_if.sv
// Trace-buffer / TAGE-phase bus of the buffer sequencer.
// Optional: TAGE_SEQ_STALL_EN adds the stall input.
interface tage_buffer_sequencer_if #(
  parameter int unsigned NUM_BUF = 2,
  parameter int unsigned DEPTH   = 16
);
  localparam int unsigned SEL_W  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_BUF-1:0] buf_ready;
  logic [NUM_BUF-1:0] buf_done;
  logic [NUM_BUF-1:0] buf_en;
  logic [SEL_W-1:0]   buf_sel;
  logic [ADDR_W-1:0]  addr;
  logic               index_tag_enable;
  logic               table_read_en;
  logic               update_predictor_enable;
  logic               update_enable;
  logic               busy;
`ifdef TAGE_SEQ_STALL_EN
  logic               stall;

  modport master (
    input  buf_ready, stall,
    output buf_done, buf_en, buf_sel, addr, index_tag_enable, table_read_en,
           update_predictor_enable, update_enable, busy
  );

  modport slave (
    output buf_ready, stall,
    input  buf_done, buf_en, buf_sel, addr, index_tag_enable, table_read_en,
           update_predictor_enable, update_enable, busy
  );
`else
  modport master (
    input  buf_ready,
    output buf_done, buf_en, buf_sel, addr, index_tag_enable, table_read_en,
           update_predictor_enable, update_enable, busy
  );

  modport slave (
    output buf_ready,
    input  buf_done, buf_en, buf_sel, addr, index_tag_enable, table_read_en,
           update_predictor_enable, update_enable, busy
  );
`endif
endinterface

// File: rtl/tage_buffer_sequencer.sv
// N-way round-robin trace-buffer sequencer driving the TAGE phase strobes.
// Optional: TAGE_SEQ_STALL_EN holds READ/PRED/UPD while stall is high.
module tage_buffer_sequencer #(
  parameter int unsigned NUM_BUF     = 2,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned READ_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  tage_buffer_sequencer_if.master bus
);
  localparam int unsigned SEL_W  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;

  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_BUF - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_INDEX, S_READ, S_PRED, S_UPD, S_STEP, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_BUF-1:0] buf_en_q, buf_en_d;
  logic [NUM_BUF-1:0] buf_done_q, buf_done_d;
  logic [NUM_BUF-1:0] sel_oh_c;
  logic               idx_q, idx_d;
  logic               rd_q, rd_d;
  logic               pred_q, pred_d;
  logic               upd_q, upd_d;
  logic               busy_q, busy_d;
  logic               hold_c;

  // Stall only freezes the table-access phases; elsewhere it has no effect.
`ifdef TAGE_SEQ_STALL_EN
  assign hold_c = bus.stall && ((state_q == S_READ) || (state_q == S_PRED) || (state_q == S_UPD));
`else
  assign hold_c = 1'b0;
`endif

  // State, counters and Moore outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      buf_en_q   <= '0;
      buf_done_q <= '0;
      idx_q      <= 1'b0;
      rd_q       <= 1'b0;
      pred_q     <= 1'b0;
      upd_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      buf_en_q   <= buf_en_d;
      buf_done_q <= buf_done_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      pred_q     <= pred_d;
      upd_q      <= upd_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, counter update and next-output decode.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    buf_en_d   = '0;
    buf_done_d = '0;
    idx_d      = 1'b0;
    rd_d       = 1'b0;
    pred_d     = 1'b0;
    upd_d      = 1'b0;
    busy_d     = 1'b0;
    sel_oh_c   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.buf_ready[sel_q]) state_d = S_SETUP;
      end
      S_SETUP: state_d = S_INDEX;
      S_INDEX: begin
        state_d = S_READ;
        cnt_d   = '0;
      end
      S_READ: begin
        if (!hold_c) begin
          if (cnt_q == CNT_LAST) state_d = S_PRED;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_PRED: begin
        if (!hold_c) state_d = S_UPD;
      end
      S_UPD: begin
        if (!hold_c) state_d = S_STEP;
      end
      S_STEP: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_DONE;
          addr_d  = '0;
        end else begin
          state_d = S_SETUP;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        if (!bus.buf_ready[sel_q]) begin
          state_d = S_IDLE;
          sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    sel_oh_c = NUM_BUF'(1) << sel_d;

    if ((state_d != S_IDLE) && (state_d != S_DONE)) buf_en_d = sel_oh_c;
    if (state_d == S_DONE) buf_done_d = sel_oh_c;
    idx_d  = (state_d == S_INDEX);
    rd_d   = (state_d == S_READ) || (state_d == S_PRED) || (state_d == S_UPD);
    // A held PRED/UPD cycle must not repeat its write strobe.
    pred_d = (state_d == S_PRED) && !hold_c;
    upd_d  = (state_d == S_UPD) && !hold_c;
    busy_d = (state_d != S_IDLE);
  end

  assign bus.buf_en                  = buf_en_q;
  assign bus.buf_done                = buf_done_q;
  assign bus.buf_sel                 = sel_q;
  assign bus.addr                    = addr_q;
  assign bus.index_tag_enable        = idx_q;
  assign bus.table_read_en           = rd_q;
  assign bus.update_predictor_enable = pred_q;
  assign bus.update_enable           = upd_q;
  assign bus.busy                    = busy_q;
endmodule

// File: tb/tb_tage_buffer_sequencer.sv
// Directed bench for tage_buffer_sequencer: three parameter sets side by side.
// Stall scenario is compiled in when TAGE_SEQ_STALL_EN is defined.
module tb_tage_buffer_sequencer;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  tage_buffer_sequencer_if #(.NUM_BUF(2), .DEPTH(16)) bus_a ();
  tage_buffer_sequencer_if #(.NUM_BUF(2), .DEPTH(3))  bus_b ();
  tage_buffer_sequencer_if #(.NUM_BUF(3), .DEPTH(5))  bus_c ();

  tage_buffer_sequencer #(.NUM_BUF(2), .DEPTH(16), .READ_CYCLES(3)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master));
  tage_buffer_sequencer #(.NUM_BUF(2), .DEPTH(3), .READ_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master));
  tage_buffer_sequencer #(.NUM_BUF(3), .DEPTH(5), .READ_CYCLES(3)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observation word: busy | done[2:0] | en[2:0] | sel[1:0] | addr[3:0] | idx rd pred upd
  logic [16:0] obs_a, obs_b, obs_c;
  assign obs_a = {bus_a.busy, 1'b0, bus_a.buf_done, 1'b0, bus_a.buf_en, 1'b0, bus_a.buf_sel,
                  bus_a.addr, bus_a.index_tag_enable, bus_a.table_read_en,
                  bus_a.update_predictor_enable, bus_a.update_enable};
  assign obs_b = {bus_b.busy, 1'b0, bus_b.buf_done, 1'b0, bus_b.buf_en, 1'b0, bus_b.buf_sel,
                  2'b00, bus_b.addr, bus_b.index_tag_enable, bus_b.table_read_en,
                  bus_b.update_predictor_enable, bus_b.update_enable};
  assign obs_c = {bus_c.busy, bus_c.buf_done, bus_c.buf_en, bus_c.buf_sel,
                  1'b0, bus_c.addr, bus_c.index_tag_enable, bus_c.table_read_en,
                  bus_c.update_predictor_enable, bus_c.update_enable};

  // Expected word for phase p of an entry (0=SETUP,1=INDEX,2..rc+1=READ,rc+2=PRED,rc+3=UPD,rc+4=STEP).
  function automatic logic [16:0] m_entry(int sel, int addr, int p, int rc);
    logic [16:0] v;
    v        = '0;
    v[16]    = 1'b1;
    v[12:10] = 3'(1 << sel);
    v[9:8]   = 2'(sel);
    v[7:4]   = 4'(addr);
    if (p == 1) v[3] = 1'b1;
    if (p >= 2 && p <= rc + 3) v[2] = 1'b1;
    if (p == rc + 2) v[1] = 1'b1;
    if (p == rc + 3) v[0] = 1'b1;
    return v;
  endfunction

  function automatic logic [16:0] m_done(int sel);
    logic [16:0] v;
    v        = '0;
    v[16]    = 1'b1;
    v[15:13] = 3'(1 << sel);
    v[9:8]   = 2'(sel);
    return v;
  endfunction

  function automatic logic [16:0] m_idle(int sel);
    logic [16:0] v;
    v      = '0;
    v[9:8] = 2'(sel);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.buf_ready = '0;
    bus_b.buf_ready = '0;
    bus_c.buf_ready = '0;
`ifdef TAGE_SEQ_STALL_EN
    bus_a.stall = 1'b0;
    bus_b.stall = 1'b0;
    bus_c.stall = 1'b0;
`endif
    tick();
    tick();
    tests_run += 3;
    if (obs_a !== 17'd0) begin tests_failed++; $display("FAIL reset_a got=%h exp=%h", obs_a, 17'd0); end
    if (obs_b !== 17'd0) begin tests_failed++; $display("FAIL reset_b got=%h exp=%h", obs_b, 17'd0); end
    if (obs_c !== 17'd0) begin tests_failed++; $display("FAIL reset_c got=%h exp=%h", obs_c, 17'd0); end
    reset = 1'b0;
    tick();
    tick();
    tests_run += 3;
    if (obs_a !== 17'd0) begin tests_failed++; $display("FAIL idle_a got=%h exp=%h", obs_a, 17'd0); end
    if (obs_b !== 17'd0) begin tests_failed++; $display("FAIL idle_b got=%h exp=%h", obs_b, 17'd0); end
    if (obs_c !== 17'd0) begin tests_failed++; $display("FAIL idle_c got=%h exp=%h", obs_c, 17'd0); end
  endtask

  task automatic test_single_buffer();
    logic [16:0] exp;
    bus_a.buf_ready = 2'b01;
    tick();
    for (int e = 0; e < 16; e++) begin
      for (int p = 0; p < 8; p++) begin
        exp = m_entry(0, e, p, 3);
        tests_run++;
        if (obs_a !== exp) begin
          tests_failed++;
          $display("FAIL single e=%0d p=%0d got=%h exp=%h", e, p, obs_a, exp);
        end
        tick();
      end
    end
    for (int k = 0; k < 2; k++) begin
      exp = m_done(0);
      tests_run++;
      if (obs_a !== exp) begin
        tests_failed++;
        $display("FAIL single_done k=%0d got=%h exp=%h", k, obs_a, exp);
      end
      if (k == 0) tick();
    end
    bus_a.buf_ready = 2'b00;
    tick();
    exp = m_idle(1);
    tests_run++;
    if (obs_a !== exp) begin tests_failed++; $display("FAIL single_ack got=%h exp=%h", obs_a, exp); end
  endtask

  task automatic test_ping_pong();
    logic [16:0] exp;
    int          sel;
    pulse_reset();
    bus_a.buf_ready = 2'b11;
    for (int s = 0; s < 3; s++) begin
      sel = s % 2;
      tick();
      for (int e = 0; e < 16; e++) begin
        for (int p = 0; p < 8; p++) begin
          exp = m_entry(sel, e, p, 3);
          tests_run++;
          if (obs_a !== exp) begin
            tests_failed++;
            $display("FAIL pingpong s=%0d e=%0d p=%0d got=%h exp=%h", s, e, p, obs_a, exp);
          end
          tick();
        end
      end
      exp = m_done(sel);
      tests_run++;
      if (obs_a !== exp) begin tests_failed++; $display("FAIL pingpong_done s=%0d got=%h exp=%h", s, obs_a, exp); end
      bus_a.buf_ready[sel] = 1'b0;
      tick();
      exp = m_idle(1 - sel);
      tests_run++;
      if (obs_a !== exp) begin tests_failed++; $display("FAIL pingpong_ack s=%0d got=%h exp=%h", s, obs_a, exp); end
      bus_a.buf_ready = (s == 2) ? 2'b00 : 2'b11;
    end
  endtask

  task automatic test_short_read();
    logic [16:0] exp;
    int n_idx, n_rd, n_pred, n_upd;
    bus_b.buf_ready = 2'b01;
    tick();
    for (int e = 0; e < 3; e++) begin
      n_idx = 0; n_rd = 0; n_pred = 0; n_upd = 0;
      for (int p = 0; p < 6; p++) begin
        exp = m_entry(0, e, p, 1);
        tests_run++;
        if (obs_b !== exp) begin
          tests_failed++;
          $display("FAIL short e=%0d p=%0d got=%h exp=%h", e, p, obs_b, exp);
        end
        n_idx  += int'(obs_b[3]);
        n_rd   += int'(obs_b[2]);
        n_pred += int'(obs_b[1]);
        n_upd  += int'(obs_b[0]);
        tick();
      end
      tests_run++;
      if (n_idx !== 1 || n_rd !== 3 || n_pred !== 1 || n_upd !== 1) begin
        tests_failed++;
        $display("FAIL short_counts e=%0d got=%0d/%0d/%0d/%0d exp=1/3/1/1", e, n_idx, n_rd, n_pred, n_upd);
      end
    end
    exp = m_done(0);
    tests_run++;
    if (obs_b !== exp) begin tests_failed++; $display("FAIL short_done got=%h exp=%h", obs_b, exp); end
    bus_b.buf_ready = 2'b00;
    tick();
    exp = m_idle(1);
    tests_run++;
    if (obs_b !== exp) begin tests_failed++; $display("FAIL short_ack got=%h exp=%h", obs_b, exp); end
  endtask

  task automatic test_three_buf();
    logic [16:0] exp;
    int          sel;
    bus_c.buf_ready = 3'b111;
    for (int s = 0; s < 4; s++) begin
      sel = s % 3;
      tick();
      for (int e = 0; e < 5; e++) begin
        for (int p = 0; p < 8; p++) begin
          exp = m_entry(sel, e, p, 3);
          tests_run++;
          if (obs_c !== exp) begin
            tests_failed++;
            $display("FAIL three s=%0d e=%0d p=%0d got=%h exp=%h", s, e, p, obs_c, exp);
          end
          tick();
        end
      end
      exp = m_done(sel);
      tests_run++;
      if (obs_c !== exp) begin tests_failed++; $display("FAIL three_done s=%0d got=%h exp=%h", s, obs_c, exp); end
      bus_c.buf_ready[sel] = 1'b0;
      tick();
      exp = m_idle((sel + 1) % 3);
      tests_run++;
      if (obs_c !== exp) begin tests_failed++; $display("FAIL three_ack s=%0d got=%h exp=%h", s, obs_c, exp); end
      bus_c.buf_ready = (s == 3) ? 3'b000 : 3'b111;
    end
  endtask

  task automatic test_async_reset();
    logic [16:0] exp;
    bus_a.buf_ready = 2'b10;
    tick();
    tick();
    tick();
    exp = m_entry(1, 0, 2, 3);
    tests_run++;
    if (obs_a !== exp) begin tests_failed++; $display("FAIL areset_pre got=%h exp=%h", obs_a, exp); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (obs_a !== 17'd0) begin tests_failed++; $display("FAIL areset_async got=%h exp=%h", obs_a, 17'd0); end
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (obs_a !== 17'd0) begin tests_failed++; $display("FAIL areset_release got=%h exp=%h", obs_a, 17'd0); end
    tick();
    tests_run++;
    if (obs_a !== 17'd0) begin tests_failed++; $display("FAIL areset_idle got=%h exp=%h", obs_a, 17'd0); end
    bus_a.buf_ready = 2'b00;
  endtask

`ifdef TAGE_SEQ_STALL_EN
  task automatic test_stall();
    logic [16:0] exp;
    int n, n_pred, n_upd, n_rd_stall;
    bus_a.buf_ready = 2'b01;
    tick();
    exp = m_entry(0, 0, 0, 3);
    tests_run++;
    if (obs_a !== exp) begin tests_failed++; $display("FAIL stall_setup got=%h exp=%h", obs_a, exp); end
    n = 0; n_pred = 0; n_upd = 0; n_rd_stall = 0;
    while (n < 40 && obs_a[7:4] != 4'd1) begin
      bus_a.stall = (n >= 2 && n <= 5);
      tick();
      n++;
      n_pred += int'(obs_a[1]);
      n_upd  += int'(obs_a[0]);
      if (n >= 3 && n <= 6) n_rd_stall += int'(obs_a[2]);
    end
    bus_a.stall = 1'b0;
    tests_run += 4;
    if (n !== 12) begin tests_failed++; $display("FAIL stall_latency got=%0d exp=12", n); end
    if (n_pred !== 1) begin tests_failed++; $display("FAIL stall_pred got=%0d exp=1", n_pred); end
    if (n_upd !== 1) begin tests_failed++; $display("FAIL stall_upd got=%0d exp=1", n_upd); end
    if (n_rd_stall !== 4) begin tests_failed++; $display("FAIL stall_read got=%0d exp=4", n_rd_stall); end
    bus_a.buf_ready = 2'b00;
    pulse_reset();
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_buffer();
    test_ping_pong();
    test_short_read();
    test_three_buf();
    test_async_reset();
`ifdef TAGE_SEQ_STALL_EN
    test_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
